// File: rtl/prio_grant_queue.sv
// Registered priority/round-robin grant queue: request pulses collect in a sticky
// pending vector and are serialised one index per handshake on a valid/ready output.
module prio_grant_queue #(
  parameter int N     = 8,
  parameter int W     = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic             rr_en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_idx,
  output logic [N-1:0]     pending,
  output logic             idle,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int PW = $clog2(N + 1);
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_reg;
  logic [W-1:0]   ptr_reg;
  logic [W-1:0]   fixed_idx;
  logic [W-1:0]   rr_idx;
  logic           rr_found;
  int             rr_pos;
  logic [W-1:0]   win_idx;
  logic           load;
  logic [N-1:0]   load_mask;
  logic [N-1:0]   dropped;
  logic [PW-1:0]  drop_pop;
  logic [SW-1:0]  drop_sum;

  // Fixed priority: ascending scan so the highest set index is the last one kept.
  always_comb begin
    fixed_idx = '0;
    for (int j = 0; j < N; j++) begin
      if (pending[j]) fixed_idx = W'(j);
    end
  end

  // Round-robin: descending scan starting just below the last winner, wrapping 0 -> N-1.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_pos   = 0;
    for (int k = 0; k < N; k++) begin
      rr_pos = int'(ptr_reg) - 1 - k;
      if (rr_pos < 0) rr_pos = rr_pos + N;
      for (int j = 0; j < N; j++) begin
        if (!rr_found && rr_pos == j && pending[j]) begin
          rr_idx   = W'(j);
          rr_found = 1'b1;
        end
      end
    end
  end

  assign win_idx = rr_en ? rr_idx : fixed_idx;
  assign load    = (pending != '0) && ((state_reg == EMPTY) || out_ready);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign load_mask[gi] = load && (win_idx == W'(gi));
      assign dropped[gi]   = req_in[gi] & pending[gi] & ~load_mask[gi];
    end
  endgenerate

  always_comb begin
    drop_pop = '0;
    for (int j = 0; j < N; j++) begin
      drop_pop = drop_pop + PW'(dropped[j]);
    end
  end

  assign drop_sum = SW'(drop_cnt) + SW'(drop_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
      out_idx   <= '0;
      ptr_reg   <= '0;
      pending   <= '0;
      drop_cnt  <= '0;
    end else begin
      pending <= (pending & ~load_mask) | req_in;
      if (drop_sum > SW'(CNT_MAX)) drop_cnt <= CNT_MAX;
      else                         drop_cnt <= CNT_W'(drop_sum);

      case (state_reg)
        EMPTY: begin
          if (load) begin
            out_idx   <= win_idx;
            ptr_reg   <= win_idx;
            state_reg <= FULL;
          end
        end
        FULL: begin
          // Back-to-back: a handshake with work pending reloads on the same edge.
          if (load) begin
            out_idx <= win_idx;
            ptr_reg <= win_idx;
          end else if (out_ready) begin
            state_reg <= EMPTY;
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

  assign out_valid = (state_reg == FULL);
  assign idle      = (pending == '0) && (state_reg == EMPTY);

endmodule

// File: tb/tb_prio_grant_queue.sv
// Directed bench for prio_grant_queue: three instances cover the default build,
// a 2-bit drop counter for saturation, and N=5 for non-power-of-two wrap.
module tb_prio_grant_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance a: N=8, CNT_W=8
  logic [7:0] a_req = '0;
  logic       a_rr = 1'b0, a_ready = 1'b0;
  logic       a_valid, a_idle;
  logic [2:0] a_idx;
  logic [7:0] a_pend, a_drop;

  // Instance b: N=8, CNT_W=2
  logic [7:0] b_req = '0;
  logic       b_rr = 1'b0, b_ready = 1'b0;
  logic       b_valid, b_idle;
  logic [2:0] b_idx;
  logic [7:0] b_pend;
  logic [1:0] b_drop;

  // Instance c: N=5, W=3
  logic [4:0] c_req = '0;
  logic       c_rr = 1'b0, c_ready = 1'b0;
  logic       c_valid, c_idle;
  logic [2:0] c_idx;
  logic [4:0] c_pend;
  logic [7:0] c_drop;

  prio_grant_queue #(.N(8), .W(3), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .req_in(a_req), .rr_en(a_rr), .out_ready(a_ready),
    .out_valid(a_valid), .out_idx(a_idx), .pending(a_pend), .idle(a_idle), .drop_cnt(a_drop));

  prio_grant_queue #(.N(8), .W(3), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .req_in(b_req), .rr_en(b_rr), .out_ready(b_ready),
    .out_valid(b_valid), .out_idx(b_idx), .pending(b_pend), .idle(b_idle), .drop_cnt(b_drop));

  prio_grant_queue #(.N(5), .W(3), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .req_in(c_req), .rr_en(c_rr), .out_ready(c_ready),
    .out_valid(c_valid), .out_idx(c_idx), .pending(c_pend), .idle(c_idle), .drop_cnt(c_drop));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  int exp_rr[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
  int exp_sat[6] = '{0, 1, 2, 3, 3, 3};

  initial begin
    // Reset state
    #2;
    chk("rst_valid", a_valid, 0);
    chk("rst_idx", a_idx, 0);
    chk("rst_pend", a_pend, 0);
    chk("rst_idle", a_idle, 1);
    chk("rst_drop", a_drop, 0);
    #1 rst = 1'b0;

    // 1: fixed priority drain of one burst
    step();
    a_ready = 1'b1;
    a_req   = 8'h94;
    step();
    a_req = '0;
    chk("t1_pend", a_pend, 8'h94);
    chk("t1_valid0", a_valid, 0);
    step(); chk("t1_idx7", a_idx, 7); chk("t1_v7", a_valid, 1);
    step(); chk("t1_idx4", a_idx, 4); chk("t1_v4", a_valid, 1);
    step(); chk("t1_idx2", a_idx, 2); chk("t1_v2", a_valid, 1);
    step(); chk("t1_done", a_valid, 0); chk("t1_idle", a_idle, 1);
    chk("t1_drop", a_drop, 0);

    // 2: backpressure holds the grant
    a_req = 8'h04;
    step();
    a_req   = '0;
    a_ready = 1'b0;
    step(); chk("t2_idx2", a_idx, 2); chk("t2_valid", a_valid, 1);
    a_req = 8'h80;
    step();
    a_req = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_idx", a_idx, 2);
      chk("t2_hold_pend", a_pend, 8'h80);
    end
    a_ready = 1'b1;
    step(); chk("t2_idx7", a_idx, 7); chk("t2_v7", a_valid, 1);
    step(); chk("t2_empty", a_valid, 0);

    // 3: round-robin then fixed with all requests asserted
    do_reset();
    a_rr    = 1'b1;
    a_ready = 1'b1;
    a_req   = 8'hFF;
    step();
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("t3_rr%0d", i), a_idx, exp_rr[i]);
    end
    a_rr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t3_fix%0d", i), a_idx, 7);
    end
    a_req = '0;

    // 4: drop counter saturation with CNT_W=2
    b_ready = 1'b0;
    b_req   = 8'h80;
    step();
    b_req = '0;
    step(); chk("t4_valid", b_valid, 1); chk("t4_idx", b_idx, 7);
    b_req = 8'h01;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t4_drop%0d", i), b_drop, exp_sat[i]);
    end
    b_req = '0;
    step(); chk("t4_hold", b_drop, 3);

    // 5: async reset between edges
    do_reset();
    a_ready = 1'b0;
    a_rr    = 1'b0;
    a_req   = 8'h80;
    step();
    a_req = 8'h0F;
    step();
    a_req = '0;
    chk("t5_pre_valid", a_valid, 1);
    chk("t5_pre_pend", a_pend, 8'h0F);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", a_valid, 0);
    chk("t5_pend", a_pend, 0);
    chk("t5_idle", a_idle, 1);
    rst = 1'b0;
    a_ready = 1'b1;
    step(); step();
    chk("t5_no_grant", a_valid, 0);
    a_req = 8'h01;
    step();
    a_req = '0;
    step(); chk("t5_new_v", a_valid, 1); chk("t5_new_idx", a_idx, 0);

    // 6: N=5 round-robin wrap
    do_reset();
    c_rr    = 1'b1;
    c_ready = 1'b1;
    c_req   = 5'b00011;
    step();
    c_req = '0;
    step(); chk("t6_g1", c_idx, 1); chk("t6_v1", c_valid, 1);
    step(); chk("t6_g0", c_idx, 0);
    step(); chk("t6_empty", c_valid, 0);
    c_req = 5'b10001;
    step();
    c_req = '0;
    step(); chk("t6_g4", c_idx, 4);
    step(); chk("t6_g0b", c_idx, 0);
    step(); chk("t6_idle", c_idle, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
